// File: rtl/stream_uart_emitter.sv
// stream_uart_emitter: byte-wide AXI-stream buffered in a FIFO and serialised onto a UART TX line
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_tdata/i_tlast/i_tvalid stream input; o_tready registered ready
//   o_uart_tx               serial line, idle high
//   o_busy                  frame in flight or FIFO / CR-LF queue non-empty
//   o_level                 FIFO occupancy 0..FIFO_DEPTH
module stream_uart_emitter #(
  parameter int CLK_FREQ_HZ = 16000000,
  parameter int BAUD = 57600,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int LAST_CRLF = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [7:0]                  i_tdata,
  input  logic                        i_tlast,
  input  logic                        i_tvalid,
  output logic                        o_tready,
  output logic                        o_uart_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);
  localparam int DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DIV);
  generate
    if (DIV < 2) begin : g_bad_div
      $error("stream_uart_emitter: baud divider must be at least 2");
    end
  endgenerate
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0] bit_idx, bit_nxt;
  logic stop_idx, stop_nxt;
  logic [7:0] tx_byte, byte_nxt;
  logic [1:0] pend, pend_nxt;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [8:0] rd_word;
  logic push, pop, load, wrap, work, par_bit, tx_nxt;
  assign push = i_tvalid & o_tready;
  assign rd_word = mem[rd_ptr];
  assign level_nxt = o_level + LW'(push) - LW'(pop);
  assign wrap = cnt == CW'(DIV - 1);
  assign work = pend != '0 || o_level != '0;
  assign o_busy = state != IDLE || o_level != '0 || pend != '0;
  assign par_bit = (PARITY == 1) ? ~^tx_byte : ^tx_byte;
  // Line level is registered from the state, so every bit lags the FSM by one cycle but keeps its full width
  assign tx_nxt = state == START ? 1'b0 :
                  state == DATA  ? tx_byte[bit_idx] :
                  state == PAR   ? par_bit : 1'b1;
  always_comb begin
    state_nxt = state;
    bit_nxt = bit_idx;
    stop_nxt = stop_idx;
    byte_nxt = tx_byte;
    pend_nxt = pend;
    pop = 1'b0;
    load = 1'b0;
    case (state)
      IDLE:  load = work;
      START: if (wrap) begin
        state_nxt = DATA;
        bit_nxt = 3'd0;
      end
      DATA:  if (wrap) begin
        if (bit_idx == 3'd7) state_nxt = (PARITY != 0) ? PAR : STOP;
        else bit_nxt = bit_idx + 3'd1;
      end
      PAR:   if (wrap) state_nxt = STOP;
      STOP:  if (wrap) begin
        if (STOP_BITS == 2 && !stop_idx) stop_nxt = 1'b1;
        else if (work) load = 1'b1;
        else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
    // Pending CR/LF always goes ahead of the FIFO; inserted bytes never re-arm insertion
    if (load) begin
      state_nxt = START;
      stop_nxt = 1'b0;
      if (pend != '0) begin
        byte_nxt = pend == 2'd2 ? 8'h0D : 8'h0A;
        pend_nxt = pend - 2'd1;
      end else begin
        pop = 1'b1;
        byte_nxt = rd_word[7:0];
        pend_nxt = (LAST_CRLF != 0 && rd_word[8]) ? 2'd2 : 2'd0;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= 3'd0;
      stop_idx <= 1'b0;
      tx_byte <= 8'h00;
      pend <= 2'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_level <= '0;
      o_tready <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      bit_idx <= bit_nxt;
      stop_idx <= stop_nxt;
      tx_byte <= byte_nxt;
      pend <= pend_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_level <= level_nxt;
      o_tready <= level_nxt < LW'(FIFO_DEPTH);
      o_uart_tx <= tx_nxt;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_tlast, i_tdata};
  end
endmodule

// File: tb/tb_stream_uart_emitter.sv
// tb_stream_uart_emitter: directed checks of four stream_uart_emitter configurations at DIV=10
module tb_stream_uart_emitter;
  localparam int DIV = 10;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic [7:0] tdata [4];
  logic [3:0] tlast, tvalid, tready, tx, busy;
  logic [2:0] lvl0;
  logic [4:0] lvl1, lvl2, lvl3;
  int checks = 0;
  int errors = 0;
  int viol = 0;
  int saw_full = 0;
  logic [15:0] bits;
  logic [7:0] crlf_exp [5] = '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h43};

  stream_uart_emitter #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1), .LAST_CRLF(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[0]), .i_tlast(tlast[0]), .i_tvalid(tvalid[0]),
    .o_tready(tready[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_level(lvl0));
  stream_uart_emitter #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1), .LAST_CRLF(0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[1]), .i_tlast(tlast[1]), .i_tvalid(tvalid[1]),
    .o_tready(tready[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_level(lvl1));
  stream_uart_emitter #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(2), .LAST_CRLF(0)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[2]), .i_tlast(tlast[2]), .i_tvalid(tvalid[2]),
    .o_tready(tready[2]), .o_uart_tx(tx[2]), .o_busy(busy[2]), .o_level(lvl2));
  stream_uart_emitter #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1), .LAST_CRLF(1)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[3]), .i_tlast(tlast[3]), .i_tvalid(tvalid[3]),
    .o_tready(tready[3]), .o_uart_tx(tx[3]), .o_busy(busy[3]), .o_level(lvl3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] frame10(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic wait_start(input int idx, input int budget, input string tag);
    int n = 0;
    while (tx[idx] && n < budget) begin
      tick;
      n++;
    end
    check(tag, 32'(tx[idx]), 32'd0);
  endtask

  // Samples every cycle of nbits bits; each bit must hold its level for exactly DIV cycles
  task automatic rx_frame(input int idx, input int nbits, input string tag, output logic [15:0] b);
    int glitch = 0;
    b = '0;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < DIV; c++) begin
        if (c == 0) b[k] = tx[idx];
        else if (tx[idx] !== b[k]) glitch++;
        tick;
      end
    end
    check({tag, "_width"}, 32'(glitch), 32'd0);
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic last);
    tdata[idx] = d;
    tlast[idx] = last;
    tvalid[idx] = 1'b1;
    tick;
    tvalid[idx] = 1'b0;
    tlast[idx] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tlast = '0;
    tvalid = '0;
    for (int i = 0; i < 4; i++) tdata[i] = 8'h00;
    repeat (3) tick;
    check("rst_tx", 32'(tx), 32'hF);
    check("rst_tready", 32'(tready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_level", 32'(lvl0), 32'd0);
    rst_n = 1'b1;
    check("rel_tready_pre", 32'(tready), 32'h0);
    tick;
    check("rel_tready", 32'(tready), 32'hF);
    begin : idle_chk
      int bad = 0;
      repeat (1000) begin
        if (tx !== 4'hF || busy !== 4'h0) bad++;
        tick;
      end
      check("idle", 32'(bad), 32'd0);
    end
    tdata[0] = 8'h55;
    tvalid[0] = 1'b1;
    tick;
    tvalid[0] = 1'b0;
    check("lat_n_tx", 32'(tx[0]), 32'd1);
    check("lat_n_level", 32'(lvl0), 32'd1);
    tick;
    check("lat_n1_tx", 32'(tx[0]), 32'd1);
    check("lat_n1_level", 32'(lvl0), 32'd0);
    tick;
    check("lat_n2_tx", 32'(tx[0]), 32'd0);
    check("busy_mid", 32'(busy[0]), 32'd1);
    rx_frame(0, 10, "b55", bits);
    check("b55_bits", 32'(bits), 32'h2AA);
    check("b55_busy_end", 32'(busy[0]), 32'd0);
    check("b55_tx_end", 32'(tx[0]), 32'd1);
    send(1, 8'h03, 1'b0);
    wait_start(1, 20, "odd_start");
    rx_frame(1, 11, "odd", bits);
    check("odd_bits", 32'(bits), 32'h606);
    check("odd_busy_end", 32'(busy[1]), 32'd0);
    send(2, 8'h03, 1'b0);
    wait_start(2, 20, "even_start");
    rx_frame(2, 12, "even", bits);
    check("even_bits", 32'(bits), 32'hC06);
    check("even_busy_end", 32'(busy[2]), 32'd0);
    check("even_tx_end", 32'(tx[2]), 32'd1);
    tdata[3] = 8'h41;
    tlast[3] = 1'b0;
    tvalid[3] = 1'b1;
    tick;
    tdata[3] = 8'h42;
    tlast[3] = 1'b1;
    tick;
    tdata[3] = 8'h43;
    tlast[3] = 1'b0;
    tick;
    tvalid[3] = 1'b0;
    wait_start(3, 20, "crlf_start");
    for (int f = 0; f < 5; f++) begin
      if (f > 0) check($sformatf("crlf_b2b%0d", f), 32'(tx[3]), 32'd0);
      rx_frame(3, 10, $sformatf("crlf%0d", f), bits);
      check($sformatf("crlf_byte%0d", f), 32'(bits), 32'(frame10(crlf_exp[f])));
    end
    check("crlf_busy_end", 32'(busy[3]), 32'd0);
    fork
      begin : drv
        int i = 0;
        int g = 0;
        logic go;
        while (i < 16 && g < 4000) begin
          tdata[0] = 8'h10 + 8'(i);
          tvalid[0] = 1'b1;
          go = tready[0];
          tick;
          g++;
          if (go) i++;
        end
        tvalid[0] = 1'b0;
      end
      begin : rcv
        logic [15:0] rb;
        for (int j = 0; j < 16; j++) begin
          wait_start(0, 400, $sformatf("fifo_start%0d", j));
          rx_frame(0, 10, $sformatf("fifo%0d", j), rb);
          check($sformatf("fifo_byte%0d", j), 32'(rb), 32'(frame10(8'h10 + 8'(j))));
        end
      end
      begin : mon
        repeat (1700) begin
          if (tready[0] !== (lvl0 < 3'd4)) viol++;
          if (lvl0 > 3'd4) viol++;
          if (lvl0 == 3'd4) saw_full = 1;
          tick;
        end
      end
    join
    check("fifo_tready_level", 32'(viol), 32'd0);
    check("fifo_full_seen", 32'(saw_full), 32'd1);
    check("fifo_drain_level", 32'(lvl0), 32'd0);
    check("fifo_drain_busy", 32'(busy[0]), 32'd0);
    tdata[0] = 8'hA5;
    tvalid[0] = 1'b1;
    tick;
    tdata[0] = 8'h5A;
    tick;
    tvalid[0] = 1'b0;
    check("rstm_level_pre", 32'(lvl0), 32'd1);
    tick;
    check("rstm_start", 32'(tx[0]), 32'd0);
    repeat (43) tick;
    check("rstm_bit3", 32'(tx[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_tx", 32'(tx[0]), 32'd1);
    check("rstm_level", 32'(lvl0), 32'd0);
    check("rstm_tready", 32'(tready[0]), 32'd0);
    check("rstm_busy", 32'(busy[0]), 32'd0);
    repeat (2) tick;
    rst_n = 1'b1;
    check("rstm_rel_pre", 32'(tready[0]), 32'd0);
    tick;
    check("rstm_rel_tready", 32'(tready[0]), 32'd1);
    check("rstm_rel_tx", 32'(tx[0]), 32'd1);
    send(0, 8'h3C, 1'b0);
    wait_start(0, 20, "post_start");
    rx_frame(0, 10, "post", bits);
    check("post_bits", 32'(bits), 32'h278);
    check("post_busy_end", 32'(busy[0]), 32'd0);
    repeat (30) tick;
    check("post_idle_tx", 32'(tx[0]), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_uart_emitter.md
Name: stream_uart_emitter

Overview:
Parametrised successor to the board-level byte emitter. Accepts a byte-wide AXI-stream (tdata/tlast/tvalid/tready) from a corescorecore-style producer, buffers it in a FIFO and serialises it onto a UART TX line. Baud, parity, stop bits and FIFO depth are configurable, and CR LF can optionally be inserted after every tlast byte. Sits between the stream producer and the o_uart_tx pin in board tops.

Parameters:
CLK_FREQ_HZ, 16000000, i_clk frequency in Hz.
BAUD, 57600, line rate; DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD, rounded; DIV >= 2 is required (elaboration error otherwise).
FIFO_DEPTH, 16, entries; power of two, >= 2.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
LAST_CRLF, 1, 1 = emit 0x0D then 0x0A after every byte tagged tlast; 0 = tlast ignored.

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  asynchronous, active-low reset.
i_tdata  in  8  stream byte.
i_tlast  in  1  end-of-message flag.
i_tvalid  in  1  stream valid.
o_tready  out  1  stream ready; registered.
o_uart_tx  out  1  serial output; idle high.
o_busy  out  1  high while a frame is on the line or the FIFO/CRLF queue is non-empty.
o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (async assert, sync release): o_uart_tx=1, o_tready=0, o_busy=0, o_level=0, FSM=IDLE, CRLF pending cleared, baud counter 0. Reset mid-frame aborts immediately; the line returns high with no partial stop bit.
- First rising edge after release: o_tready=1.
- FIFO: 9-bit entries {tlast,tdata}. Push on i_tvalid & o_tready. o_tready is registered as (next occupancy < FIFO_DEPTH). Simultaneous push and pop at full: pop frees a slot but o_tready stays low that cycle; no data lost, none overwritten. Pop on empty never occurs.
- FSM states: IDLE, START, DATA, PAR, STOP.
  IDLE: if a CR/LF is pending, load it; else if FIFO non-empty, pop and load; then go to START. Otherwise stay, tx=1.
  START: tx=0 for DIV cycles.
  DATA: 8 bits, LSB first, DIV cycles each.
  PAR: present only if PARITY!=0. Odd: total ones in data+parity is odd. Even: the total is even.
  STOP: tx=1 for STOP_BITS*DIV cycles. At the end, if more work is pending, load the next byte and enter START directly (no idle gap). Else go to IDLE.
- Latency: a push at edge N into an empty FIFO with IDLE FSM → pop at edge N+1 → tx low from edge N+2.
- Frame length: DIV*(10 + (PARITY!=0) + (STOP_BITS-1)) cycles.
- CRLF: when a byte with tlast=1 is loaded and LAST_CRLF=1, set pending=2. The next two frames are 0x0D and 0x0A, sent before any further FIFO pop; the FIFO keeps accepting data meanwhile. The CR/LF bytes themselves never retrigger insertion.
- Baud counter: counts 0..DIV-1 and wraps. Bit transitions occur only on wrap, so every bit is exactly DIV cycles.
- o_busy = (FSM!=IDLE) | (o_level!=0) | (pending!=0).
- o_level: updated on the same edge as push/pop; simultaneous push+pop leaves it unchanged.

Test Plan:
- CLK_FREQ_HZ=1000000, BAUD=100000 (DIV=10), PARITY=0, LAST_CRLF=0; send 0x55 → tx low at edge N+2; pattern 0,1,0,1,0,1,0,1,0,1 at 10 cycles/bit; 100 cycles total; o_busy drops after the stop bit.
- PARITY=1 with byte 0x03, then PARITY=2 with byte 0x03 → parity bit 1 then 0; frame 110 cycles; STOP_BITS=2 → stop high for 20 cycles.
- LAST_CRLF=1; send 0x41 (tlast=0), 0x42 (tlast=1), 0x43 → line carries 0x41, 0x42, 0x0D, 0x0A, 0x43 back-to-back, each start bit immediately following the previous stop.
- FIFO_DEPTH=4; hold tvalid high with bytes 0x10..0x1F → o_tready drops once o_level=4; all 16 bytes are emitted in order with none lost; o_level never exceeds 4.
- Assert i_rst_n=0 during data bit 3 of a frame → o_uart_tx=1, o_level=0, o_tready=0 in the same cycle; after release, o_tready=1 on the first edge and the next byte sent is clean.
- Idle check: no input for 1000 cycles after reset → o_uart_tx constantly 1, o_busy=0.
